data_buf: RTL and testbench

DATA_BUF -- requirements
Module: data_buf

---
 rtl/data_buf.sv | 66 ++++++
 tb/tb_data_buf.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_buf.sv
// data_buf: DEPTH x WIDTH register-file buffer with one always-on write port
// and PORT_NUM independent registered read ports. Reads are read-first with a
// latency of one cycle, and out-of-range addresses read as zero. A synchronous
// active-low reset clears both the storage and the read registers.
module data_buf #(
    parameter int DEPTH      = 32,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int PORT_NUM   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH*PORT_NUM-1:0] rd_addr_NP,
    output logic [WIDTH*PORT_NUM-1:0]      rd_data_NP,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_1P,
    input  logic [WIDTH-1:0]               wr_data_1P
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit keeps the range check a true unsigned compare over the
    // full address, so a high address bit can never alias into the array.
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]                 mem [DEPTH];
    logic [PORT_NUM-1:0][WIDTH-1:0]   rd_q;

    logic                             wr_hit;
    logic [IDX_W-1:0]                 wr_idx;
    logic [PORT_NUM-1:0]              rd_hit;
    logic [PORT_NUM-1:0][IDX_W-1:0]   rd_idx;

    assign wr_hit = {1'b0, wr_addr_1P} < DEPTH_X;
    assign wr_idx = wr_addr_1P[IDX_W-1:0];

    // Per-port address decode. The low bits index the array. They are only
    // used when the full-width compare says the address is in range.
    for (genvar k = 0; k < PORT_NUM; k++) begin : g_rd_dec
        assign rd_hit[k] = {1'b0, rd_addr_NP[k*ADDR_WIDTH +: ADDR_WIDTH]} < DEPTH_X;
        assign rd_idx[k] = rd_addr_NP[k*ADDR_WIDTH +: IDX_W];
    end

    // Storage: cleared on reset, otherwise written every cycle the address is in range.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_hit) begin
            mem[wr_idx] <= wr_data_1P;
        end
    end

    // Read registers: sample pre-write contents (read-first); zero when out of range.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            for (int k = 0; k < PORT_NUM; k++)
                rd_q[k] <= rd_hit[k] ? mem[rd_idx[k]] : '0;
        end
    end

    // Outputs come straight from the read registers, so no input reaches them combinationally.
    assign rd_data_NP = rd_q;

endmodule

// File: tb/tb_data_buf.sv
// tb_data_buf: directed scenarios plus randomized traffic for data_buf. Each
// cycle is checked against an array model. The model predicts the registered
// read data from the storage state before the clock edge, then applies reset
// or the write.
module tb_data_buf;

    localparam int DEPTH = 32;
    localparam int WIDTH = 16;
    localparam int AW    = 32;
    localparam int NP    = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [AW*NP-1:0]    rd_addr_NP;
    logic [WIDTH*NP-1:0] rd_data_NP;
    logic [AW-1:0]       wr_addr_1P;
    logic [WIDTH-1:0]    wr_data_1P;

    logic [AW-1:0]       ra [NP];
    int unsigned         model [DEPTH];
    int                  total = 0;
    int                  bad   = 0;

    data_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW), .PORT_NUM(NP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_NP (rd_addr_NP),
        .rd_data_NP (rd_data_NP),
        .wr_addr_1P (wr_addr_1P),
        .wr_data_1P (wr_data_1P)
    );

    always #5 clk = ~clk;

    assign rd_addr_NP = {ra[3], ra[2], ra[1], ra[0]};

    function automatic logic [WIDTH-1:0] slice(input int k);
        return rd_data_NP[k*WIDTH +: WIDTH];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Predict the read results from the model, update the
    // model, then compare every port after the edge.
    task automatic step();
        int unsigned exp [NP];
        for (int k = 0; k < NP; k++)
            exp[k] = (!rst_n || ra[k] >= DEPTH) ? 0 : model[ra[k]];
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 0;
        end else if (wr_addr_1P < DEPTH) begin
            model[wr_addr_1P] = wr_data_1P;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NP; k++)
            chk($sformatf("model_p%0d", k), slice(k), exp[k]);
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom % 5)
            0, 1:    return AW'($urandom % DEPTH);
            2:       return AW'(DEPTH + ($urandom % 32));
            3:       return 32'h8000_0000 | AW'($urandom % DEPTH);
            default: return AW'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        set_rd(0, 0, 0, 0);
        wr_addr_1P = 1000;
        wr_data_1P = 16'hAAAA;
        for (int i = 0; i < DEPTH; i++) model[i] = 0;

        // Reset held for 10 cycles.
        repeat (10) step();
        for (int k = 0; k < NP; k++) chk("rst_out", slice(k), 0);

        // Reads after release and before any write return zero.
        rst_n = 1'b1;
        set_rd(0, 1, 2, 3);
        step();
        for (int k = 0; k < NP; k++) chk("post_rst_rd", slice(k), 0);

        // Sequential fill.
        set_rd(1, 2, 3, 4);
        for (int a = 0; a < DEPTH; a++) begin
            wr_addr_1P = a;
            wr_data_1P = (a == 0) ? 16'd0 : 16'(a + 2);
            step();
        end
        wr_addr_1P = 1000;
        step();
        for (int k = 0; k < NP; k++) chk("fill_rd", slice(k), k + 3);

        // Address change: old data is held until the next edge.
        set_rd(7, 8, 9, 10);
        #2;
        for (int k = 0; k < NP; k++) chk("addr_hold", slice(k), k + 3);
        step();
        for (int k = 0; k < NP; k++) chk("addr_change", slice(k), k + 9);

        // Out-of-range write and read.
        wr_addr_1P = 32;
        wr_data_1P = 16'hFFFF;
        set_rd(1, 2, 40, 4);
        step();
        chk("oor_p0", slice(0), 3);
        chk("oor_p1", slice(1), 4);
        chk("oor_p2", slice(2), 0);
        chk("oor_p3", slice(3), 6);
        wr_addr_1P = 32'h8000_0001;
        step();
        wr_addr_1P = 1000;
        for (int b = 0; b < DEPTH; b += NP) begin
            set_rd(b, b + 1, b + 2, b + 3);
            step();
        end

        // Read/write collision is read-first.
        wr_addr_1P = 5;
        wr_data_1P = 16'h1234;
        set_rd(5, 5, 6, 5);
        step();
        chk("coll_old", slice(0), 7);
        chk("coll_same", slice(1), 7);
        wr_addr_1P = 1000;
        step();
        chk("coll_new", slice(0), 16'h1234);
        chk("coll_new3", slice(3), 16'h1234);

        // A reset glitch between edges has no effect.
        set_rd(1, 2, 3, 4);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        for (int k = 0; k < NP; k++) chk("rst_glitch", slice(k), k + 3);

        // Mid-operation reset pulse.
        rst_n = 1'b0;
        step();
        for (int k = 0; k < NP; k++) chk("mid_rst", slice(k), 0);
        rst_n = 1'b1;
        step();
        for (int k = 0; k < NP; k++) chk("mid_rst_rd", slice(k), 0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom % 60) != 0;
            for (int k = 0; k < NP; k++) ra[k] = rand_addr();
            if ($urandom % 4 == 0) ra[1] = ra[0];
            wr_addr_1P = ($urandom % 3 == 0) ? rand_addr() : AW'($urandom % DEPTH);
            if ($urandom % 6 == 0) ra[2] = wr_addr_1P;
            wr_data_1P = 16'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
